// File: rtl/fft_lane_checker_pkg.sv
// rtl/fft_lane_checker_pkg.sv - shared FSM encodings for the FFT lane checker
package fft_lane_checker_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SKIP  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/fft_lane_checker_if.sv
// rtl/fft_lane_checker_if.sv - beat bus carrying DUT and golden lane words
interface fft_lane_checker_if #(
    parameter int NBITS_OUT = 15,
    parameter int LANES     = 4
);
    logic                         in_valid;
    logic [LANES*2*NBITS_OUT-1:0] dut_data;
    logic [LANES*2*NBITS_OUT-1:0] exp_data;

    modport master (output in_valid, dut_data, exp_data);
    modport slave  (input  in_valid, dut_data, exp_data);
endinterface

// File: rtl/fft_cplx_cmp.sv
// rtl/fft_cplx_cmp.sv - combinational compare of one complex lane word {re,im}
module fft_cplx_cmp #(
    parameter int NBITS_OUT = 15,
    parameter int TOL       = 1
) (
    input  logic [2*NBITS_OUT-1:0] dutWord,
    input  logic [2*NBITS_OUT-1:0] expWord,
    input  logic                   tolEn,
    output logic                   match
);
    localparam int NB = NBITS_OUT;
    localparam logic [NB:0] TOL_V = (NB+1)'(TOL);

    logic signed [NB:0] diffRe;
    logic signed [NB:0] diffIm;
    logic        [NB:0] magRe;
    logic        [NB:0] magIm;

    always_comb begin
        // one guard bit keeps full-scale opposite-sign differences exact
        diffRe = $signed({dutWord[2*NB-1], dutWord[2*NB-1:NB]})
               - $signed({expWord[2*NB-1], expWord[2*NB-1:NB]});
        diffIm = $signed({dutWord[NB-1], dutWord[NB-1:0]})
               - $signed({expWord[NB-1], expWord[NB-1:0]});
        magRe  = diffRe[NB] ? $unsigned(-diffRe) : $unsigned(diffRe);
        magIm  = diffIm[NB] ? $unsigned(-diffIm) : $unsigned(diffIm);
        match  = tolEn ? ((magRe <= TOL_V) && (magIm <= TOL_V)) : (dutWord == expWord);
    end
endmodule

// File: rtl/fft_lane_checker.sv
// rtl/fft_lane_checker.sv - per-beat scoreboard for the parallel FFT output stream
module fft_lane_checker
    import fft_lane_checker_pkg::*;
#(
    parameter int NBITS_OUT = 15,
    parameter int LANES     = 4,
    parameter int N         = 128,
    parameter int TOL       = 1,
    parameter int CNT_W     = 16,
    localparam int BEATS    = N / LANES,
    localparam int BT_W     = $clog2(BEATS),
    localparam int LN_W     = $clog2(LANES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   start,
    input  logic                   tol_en,
    input  logic [7:0]             skip_beats,
    input  logic [CNT_W-1:0]       num_frames,
    fft_lane_checker_if.slave      beat,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [LANES-1:0]       lane_match,
    output logic [CNT_W-1:0]       err_count,
    output logic [CNT_W-1:0]       frame_cnt,
    output logic                   first_err_v,
    output logic [CNT_W-1:0]       first_err_fr,
    output logic [BT_W-1:0]        first_err_bt,
    output logic [LN_W-1:0]        first_err_ln
);
    localparam int LW = 2 * NBITS_OUT;

    logic [1:0]       state;
    logic             tolEnQ;
    logic [7:0]       skipLeft;
    logic [CNT_W-1:0] framesQ;
    logic [BT_W-1:0]  beatCnt;
    logic [LANES-1:0] laneOk;
    logic [CNT_W:0]   missCnt;
    logic [CNT_W:0]   errSum;
    logic [LN_W-1:0]  lowLane;
    logic             lastBeat;

    for (genvar k = 0; k < LANES; k++) begin : gLane
        fft_cplx_cmp #(.NBITS_OUT(NBITS_OUT), .TOL(TOL)) uCmp (
            .dutWord (beat.dut_data[k*LW +: LW]),
            .expWord (beat.exp_data[k*LW +: LW]),
            .tolEn   (tolEnQ),
            .match   (laneOk[k])
        );
    end

    always_comb begin
        missCnt = '0;
        lowLane = '0;
        // descending scan leaves the lowest failing lane in lowLane
        for (int k = LANES - 1; k >= 0; k--) begin
            missCnt = missCnt + {{CNT_W{1'b0}}, ~laneOk[k]};
            if (!laneOk[k]) lowLane = LN_W'(k);
        end
        errSum   = {1'b0, err_count} + missCnt;
        lastBeat = (beatCnt == BT_W'(BEATS - 1));
    end

    assign busy = (state == ST_SKIP) || (state == ST_CHECK);
    assign done = (state == ST_DONE);
    assign pass = done && (err_count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            tolEnQ       <= 1'b0;
            skipLeft     <= '0;
            framesQ      <= '0;
            beatCnt      <= '0;
            lane_match   <= '1;
            err_count    <= '0;
            frame_cnt    <= '0;
            first_err_v  <= 1'b0;
            first_err_fr <= '0;
            first_err_bt <= '0;
            first_err_ln <= '0;
        end else if (clear) begin
            state        <= ST_IDLE;
            tolEnQ       <= 1'b0;
            skipLeft     <= '0;
            framesQ      <= '0;
            beatCnt      <= '0;
            lane_match   <= '1;
            err_count    <= '0;
            frame_cnt    <= '0;
            first_err_v  <= 1'b0;
            first_err_fr <= '0;
            first_err_bt <= '0;
            first_err_ln <= '0;
        end else if (start && !busy) begin
            tolEnQ       <= tol_en;
            skipLeft     <= skip_beats;
            framesQ      <= num_frames;
            beatCnt      <= '0;
            err_count    <= '0;
            frame_cnt    <= '0;
            first_err_v  <= 1'b0;
            first_err_fr <= '0;
            first_err_bt <= '0;
            first_err_ln <= '0;
            if (num_frames == '0)      state <= ST_DONE;
            else if (skip_beats != '0) state <= ST_SKIP;
            else                       state <= ST_CHECK;
        end else if (beat.in_valid) begin
            case (state)
                ST_SKIP: begin
                    skipLeft <= skipLeft - 8'd1;
                    if (skipLeft == 8'd1) state <= ST_CHECK;
                end
                ST_CHECK: begin
                    lane_match <= laneOk;
                    err_count  <= errSum[CNT_W] ? {CNT_W{1'b1}} : errSum[CNT_W-1:0];
                    if (!first_err_v && (laneOk != '1)) begin
                        first_err_v  <= 1'b1;
                        first_err_fr <= frame_cnt;
                        first_err_bt <= beatCnt;
                        first_err_ln <= lowLane;
                    end
                    if (lastBeat) begin
                        beatCnt   <= '0;
                        frame_cnt <= frame_cnt + 1'b1;
                        if (frame_cnt == framesQ - 1'b1) state <= ST_DONE;
                    end else begin
                        beatCnt <= beatCnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_lane_checker.sv
// tb/tb_fft_lane_checker.sv - table, sequence and randomized checks of fft_lane_checker
module tb_fft_lane_checker;
    localparam int NB     = 15;
    localparam int LANES  = 4;
    localparam int N      = 128;
    localparam int TOL    = 1;
    localparam int CNT_W  = 16;
    localparam int CNT_W2 = 4;
    localparam int BEATS  = N / LANES;
    localparam int LW     = 2 * NB;
    localparam int DW     = LANES * LW;
    localparam int BT_W   = $clog2(BEATS);
    localparam int LN_W   = $clog2(LANES);
    localparam int MAX16  = 65535;

    logic clk = 1'b0, rst = 1'b0, clear = 1'b0, start = 1'b0, start2 = 1'b0, tol_en = 1'b0;
    logic [7:0]        skip_beats = '0;
    logic [CNT_W-1:0]  num_frames = '0;
    logic [CNT_W2-1:0] num_frames2 = '0;

    logic busy, done, pass, first_err_v;
    logic [LANES-1:0] lane_match;
    logic [CNT_W-1:0] err_count, frame_cnt, first_err_fr;
    logic [BT_W-1:0]  first_err_bt;
    logic [LN_W-1:0]  first_err_ln;
    logic busy2, done2, pass2, first_err_v2;
    logic [LANES-1:0]  lane_match2;
    logic [CNT_W2-1:0] err_count2, frame_cnt2, first_err_fr2;
    logic [BT_W-1:0]   first_err_bt2;
    logic [LN_W-1:0]   first_err_ln2;

    fft_lane_checker_if #(.NBITS_OUT(NB), .LANES(LANES)) beatBus ();

    fft_lane_checker #(.NBITS_OUT(NB), .LANES(LANES), .N(N), .TOL(TOL), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .start(start), .tol_en(tol_en),
        .skip_beats(skip_beats), .num_frames(num_frames), .beat(beatBus),
        .busy(busy), .done(done), .pass(pass), .lane_match(lane_match),
        .err_count(err_count), .frame_cnt(frame_cnt), .first_err_v(first_err_v),
        .first_err_fr(first_err_fr), .first_err_bt(first_err_bt), .first_err_ln(first_err_ln)
    );

    fft_lane_checker #(.NBITS_OUT(NB), .LANES(LANES), .N(N), .TOL(TOL), .CNT_W(CNT_W2)) dut2 (
        .clk(clk), .rst(rst), .clear(clear), .start(start2), .tol_en(tol_en),
        .skip_beats(skip_beats), .num_frames(num_frames2), .beat(beatBus),
        .busy(busy2), .done(done2), .pass(pass2), .lane_match(lane_match2),
        .err_count(err_count2), .frame_cnt(frame_cnt2), .first_err_v(first_err_v2),
        .first_err_fr(first_err_fr2), .first_err_bt(first_err_bt2), .first_err_ln(first_err_ln2)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              valid;
        bit              st;
        logic [DW-1:0]   dut;
        logic [DW-1:0]   gold;
    } beat_t;

    typedef struct {
        bit tol;
        int dRe, dIm, eRe, eIm;
        int errs;
    } vec_t;

    beat_t stream[$];
    int    expLm[$];
    int    mErr, mFrames, mDoneIdx, mFev, mFfr, mFbt, mFln;
    int    nChecks = 0;
    int    nFails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        nChecks++;
        if (act !== want) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int compOf(input logic [DW-1:0] w, input int lane, input bit im);
        logic [LW-1:0] lw;
        lw = w[lane*LW +: LW];
        return im ? int'($signed(lw[NB-1:0])) : int'($signed(lw[LW-1:NB]));
    endfunction

    function automatic logic [DW-1:0] setLane(input logic [DW-1:0] w, input int lane, input int re, input int im);
        logic [NB-1:0] r;
        logic [NB-1:0] i2;
        r = NB'(re);
        i2 = NB'(im);
        w[lane*LW +: LW] = {r, i2};
        return w;
    endfunction

    function automatic logic [DW-1:0] randWord();
        return DW'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    task automatic buildStream(input int nValid, input int gapPct);
        int v;
        beat_t b;
        stream = {};
        v = 0;
        while (v < nValid) begin
            b.st = 1'b0;
            b.gold = randWord();
            if (int'($urandom_range(99)) < gapPct) begin
                b.valid = 1'b0;
                b.dut = randWord();
            end else begin
                b.valid = 1'b1;
                b.dut = b.gold;
                v++;
            end
            stream.push_back(b);
        end
    endtask

    function automatic int validIdx(input int j);
        int c;
        c = 0;
        foreach (stream[i]) begin
            if (stream[i].valid) begin
                if (c == j) return i;
                c++;
            end
        end
        return 0;
    endfunction

    task automatic corrupt(input int j, input int lane, input int dRe, input int dIm);
        int i;
        i = validIdx(j);
        stream[i].dut = setLane(stream[i].dut, lane,
                                compOf(stream[i].dut, lane, 1'b0) + dRe,
                                compOf(stream[i].dut, lane, 1'b1) + dIm);
    endtask

    // Reference: walk valid beats, drop the first `skip`, then position = index / BEATS.
    task automatic runModel(input bit tol, input int skip, input int frames, input int cntMax);
        int v, lastLm, j, mask, dr, di;
        bit ok;
        v = 0; lastLm = -1;
        mErr = 0; mFrames = 0; mDoneIdx = -1; mFev = 0; mFfr = 0; mFbt = 0; mFln = 0;
        expLm = {};
        foreach (stream[i]) begin
            if (stream[i].valid && mDoneIdx < 0) begin
                if (v >= skip) begin
                    j = v - skip;
                    mask = 0;
                    for (int k = 0; k < LANES; k++) begin
                        dr = compOf(stream[i].dut, k, 1'b0) - compOf(stream[i].gold, k, 1'b0);
                        di = compOf(stream[i].dut, k, 1'b1) - compOf(stream[i].gold, k, 1'b1);
                        ok = tol ? (iabs(dr) <= TOL && iabs(di) <= TOL) : (dr == 0 && di == 0);
                        if (ok) mask |= (1 << k);
                        else begin
                            mErr = (mErr < cntMax) ? mErr + 1 : cntMax;
                            if (mFev == 0) begin
                                mFev = 1; mFfr = j / BEATS; mFbt = j % BEATS; mFln = k;
                            end
                        end
                    end
                    lastLm = mask;
                    if (j % BEATS == BEATS - 1) begin
                        mFrames++;
                        if (j / BEATS == frames - 1) mDoneIdx = i;
                    end
                end
                v++;
            end
            expLm.push_back(lastLm);
        end
    endtask

    task automatic startRun(input bit second, input bit tol, input int skip, input int frames);
        tol_en = tol;
        skip_beats = 8'(skip);
        if (second) begin
            start2 = 1'b1;
            num_frames2 = CNT_W2'(frames);
        end else begin
            start = 1'b1;
            num_frames = CNT_W'(frames);
        end
        @(negedge clk);
        start = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic drive(input int limit, input bit chk);
        for (int i = 0; i < stream.size() && i < limit; i++) begin
            beatBus.in_valid = stream[i].valid;
            beatBus.dut_data = stream[i].dut;
            beatBus.exp_data = stream[i].gold;
            start      = stream[i].st;
            tol_en     = 1'($urandom());
            skip_beats = 8'($urandom());
            num_frames = stream[i].st ? '0 : CNT_W'($urandom());
            @(negedge clk);
            if (chk) begin
                if (expLm[i] >= 0) check($sformatf("lane_match@%0d", i), lane_match, expLm[i]);
                check($sformatf("done@%0d", i), done, (mDoneIdx >= 0 && i >= mDoneIdx));
            end
        end
        beatBus.in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic checkFinal(input string tag);
        check({tag, "_done"}, done, (mDoneIdx >= 0));
        check({tag, "_err"}, err_count, mErr);
        check({tag, "_frames"}, frame_cnt, mFrames);
        check({tag, "_pass"}, pass, (mDoneIdx >= 0 && mErr == 0));
        check({tag, "_fev"}, first_err_v, mFev);
        if (mFev != 0) begin
            check({tag, "_ffr"}, first_err_fr, mFfr);
            check({tag, "_fbt"}, first_err_bt, mFbt);
            check({tag, "_fln"}, first_err_ln, mFln);
        end
    endtask

    task automatic checkIdle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_lm"}, lane_match, 4'hF);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_frames"}, frame_cnt, 0);
        check({tag, "_fev"}, first_err_v, 0);
        check({tag, "_fpos"}, {first_err_fr, first_err_bt, first_err_ln}, 0);
        check({tag, "_d2"}, {busy2, done2, pass2, first_err_v2}, 0);
        check({tag, "_d2cnt"}, {err_count2, frame_cnt2, first_err_fr2, first_err_bt2, first_err_ln2}, 0);
        check({tag, "_d2lm"}, lane_match2, 4'hF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   nv, sk, fr;
        bit   tl;
        vecs[0] = '{0,   100,   -5,   100,   -5, 0};
        vecs[1] = '{0,   101,   -5,   100,   -5, 1};
        vecs[2] = '{1,   101,   -5,   100,   -5, 0};
        vecs[3] = '{1,    99,   -6,   100,   -5, 0};
        vecs[4] = '{1,   102,   -5,   100,   -5, 1};
        vecs[5] = '{1,   100,   -7,   100,   -5, 1};
        vecs[6] = '{1, -16384,   0,  16383,    0, 1};
        vecs[7] = '{1,  16383,   0, -16384,    0, 1};
        vecs[8] = '{0, -16384, 16383, -16384, 16383, 0};
        vecs[9] = '{1, -16384, -16384, -16383, 16383, 1};

        beatBus.in_valid = 1'b0;
        beatBus.dut_data = '0;
        beatBus.exp_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkIdle("reset");

        // skip 3 junk beats, then two clean frames
        buildStream(3 + 2*BEATS + 3, 0);
        for (int j = 0; j < 3; j++) corrupt(j, j, 5, -3);
        corrupt(3 + 2*BEATS + 2, 0, 1, 0);
        runModel(0, 3, 2, MAX16);
        startRun(0, 0, 3, 2);
        drive(1000, 1);
        checkFinal("t1");
        check("t1_frames_const", frame_cnt, 2);
        check("t1_pass_const", pass, 1);

        // single +1 error at frame 1, beat 5, lane 2
        buildStream(2*BEATS + 2, 25);
        corrupt(BEATS + 5, 2, 1, 0);
        corrupt(2*BEATS + 1, 1, 9, 9);
        runModel(0, 0, 2, MAX16);
        startRun(0, 0, 0, 2);
        drive(1000, 1);
        checkFinal("t2");
        check("t2_err_const", err_count, 1);
        check("t2_pos_const", {first_err_fr, first_err_bt, first_err_ln}, {16'd1, 5'd5, 2'd2});
        check("t2_pass_const", pass, 0);

        runModel(1, 0, 2, MAX16);
        startRun(0, 1, 0, 2);
        drive(1000, 1);
        checkFinal("t3");
        check("t3_pass_const", pass, 1);

        for (int n = 0; n < 10; n++) begin
            buildStream(BEATS, 10);
            nv = validIdx(3);
            stream[nv].dut  = setLane(stream[nv].dut, 1, vecs[n].dRe, vecs[n].dIm);
            stream[nv].gold = setLane(stream[nv].gold, 1, vecs[n].eRe, vecs[n].eIm);
            runModel(vecs[n].tol, 0, 1, MAX16);
            startRun(0, vecs[n].tol, 0, 1);
            drive(1000, 1);
            checkFinal($sformatf("vec%0d", n));
            check($sformatf("vec%0d_err_const", n), err_count, vecs[n].errs);
        end

        // narrow counter instance: 32 lane errors saturate at 15
        buildStream(BEATS, 0);
        for (int j = 0; j < 8; j++)
            for (int k = 0; k < LANES; k++) corrupt(j, k, 1, 1);
        runModel(0, 0, 1, 15);
        startRun(1, 0, 0, 1);
        drive(1000, 0);
        check("sat_done", done2, 1);
        check("sat_err_model", err_count2, mErr);
        check("sat_err_const", err_count2, 15);
        check("sat_frames", frame_cnt2, 1);

        // asynchronous reset mid-CHECK
        buildStream(2*BEATS, 0);
        corrupt(1, 0, 3, 0);
        corrupt(2, 1, 0, 2);
        startRun(0, 0, 0, 2);
        drive(10, 0);
        check("rst_pre_busy", busy, 1);
        #2 rst = 1'b0;
        #1 checkIdle("rst_async");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkIdle("rst_after");

        // clear wins over start and in_valid
        startRun(0, 0, 0, 2);
        drive(10, 0);
        check("clr_pre_busy", busy, 1);
        clear = 1'b1;
        start = 1'b1;
        num_frames = '0;
        beatBus.in_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        beatBus.in_valid = 1'b0;
        checkIdle("clear");
        @(negedge clk);
        check("clear_stay_busy", busy, 0);
        check("clear_stay_done", done, 0);

        startRun(0, 0, 5, 0);
        check("f0_done", done, 1);
        check("f0_pass", pass, 1);
        check("f0_busy", busy, 0);

        // random runs with gaps, small errors and an ignored mid-run start
        for (int r = 0; r < 6; r++) begin
            tl = 1'($urandom());
            sk = int'($urandom_range(0, 5));
            fr = int'($urandom_range(1, 3));
            buildStream(sk + fr*BEATS + 4, 20);
            for (int c = 0; c < int'($urandom_range(0, 6)); c++)
                corrupt(int'($urandom_range(0, sk + fr*BEATS + 3)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 4)) - 2);
            stream[5].st = 1'b1;
            runModel(tl, sk, fr, MAX16);
            startRun(0, tl, sk, fr);
            drive(1000, 1);
            checkFinal($sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
